// File: rtl/ram_8.sv
// Eight-entry register-file RAM: one decoded synchronous write port and a
// combinational read port sharing the same select.
module ram_8 #(
  parameter int WIDTH  = 20,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] sel,
  output logic [WIDTH-1:0]  OUT
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            we;

  // One-hot write enable; LOAD gates the whole decoder.
  always_comb begin
    we = '0;
    if (LOAD) we[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (reset)      mem[k] <= '0;
      else if (we[k]) mem[k] <= IN;
    end
  end

  // No bypass: a same-entry write shows up only after the edge.
  assign OUT = mem[sel];

endmodule

// File: tb/tb_ram_8.sv
// Directed bench for ram_8: vector table plus a few multi-cycle sequences.
module tb_ram_8;
  localparam int WIDTH  = 20;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              LOAD;
  logic [WIDTH-1:0]  IN;
  logic [ADDR_W-1:0] sel;
  logic [WIDTH-1:0]  OUT;

  ram_8 #(.WIDTH(WIDTH), .DEPTH(8), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .LOAD(LOAD), .IN(IN), .sel(sel), .OUT(OUT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              load;
    logic [ADDR_W-1:0] s;
    logic [WIDTH-1:0]  d;
    logic              edge_en;
    logic [WIDTH-1:0]  exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic r, logic l, int s, int d, logic e, int x);
    vec_t v;
    v.rst = r; v.load = l; v.s = ADDR_W'(s); v.d = WIDTH'(d);
    v.edge_en = e; v.exp = WIDTH'(x);
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [WIDTH-1:0] exp);
    checks++;
    if (OUT !== exp) begin
      errors++;
      $display("FAIL %s: OUT=%05h expected %05h (sel=%0d)", name, OUT, exp, sel);
    end
  endtask

  initial begin
    reset = 1'b0; LOAD = 1'b0; IN = '0; sel = '0;

    // Reset, then read sweep
    add(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, i, 0, 0, 0);
    // Single write/read
    add(0, 1, 0, 15, 1, 15);
    add(0, 1, 3, 3, 1, 3);
    add(0, 0, 0, 0, 0, 15);
    add(0, 0, 3, 0, 0, 3);
    // Fill sweep, then read back every entry
    for (int i = 0; i < 8; i++) add(0, 1, i, i, 1, i);
    for (int i = 0; i < 8; i++) add(0, 0, i, 0, 0, i);
    // Write inhibit
    for (int i = 0; i < 8; i++) add(0, 0, i, i + 2, 1, i);
    // Reset beats a simultaneous load
    add(1, 1, 5, 'hABCDE, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, i, 'h12345, 0, 0);
    // Full-width values, combinational toggling without edges
    add(0, 1, 7, 'hFFFFF, 1, 'hFFFFF);
    add(0, 1, 6, 'h00001, 1, 'h00001);
    add(0, 0, 7, 0, 0, 'hFFFFF);
    add(0, 0, 6, 0, 0, 'h00001);
    add(0, 0, 7, 0, 0, 'hFFFFF);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; LOAD = vecs[i].load;
      sel = vecs[i].s;     IN = vecs[i].d;
      if (vecs[i].edge_en) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Read-during-write on the same entry: old before the edge, new after
    @(negedge clk);
    reset = 1'b0; LOAD = 1'b1; sel = 3'd7; IN = 20'h5A5A5;
    #1 check("rdw_before", 20'hFFFFF);
    @(posedge clk); #1 check("rdw_after", 20'h5A5A5);

    // Mid-cycle sel/IN churn is ignored; only edge-time values land
    @(negedge clk);
    LOAD = 1'b1; sel = 3'd2; IN = 20'h11111;
    #1 sel = 3'd4; IN = 20'h22222;
    #1 sel = 3'd1; IN = 20'h33333;
    @(posedge clk); #1 check("churn_written", 20'h33333);
    @(negedge clk);
    LOAD = 1'b0; sel = 3'd2;
    #1 check("churn_sel2_untouched", 20'h00000);
    sel = 3'd4;
    #1 check("churn_sel4_untouched", 20'h00000);

    // LOAD dropped: no write at the edge even with fresh sel/IN
    @(negedge clk);
    LOAD = 1'b0; sel = 3'd1; IN = 20'h0F0F0;
    @(posedge clk); #1 check("load_low_hold", 20'h33333);

    // Writes resume after reset on the first reset=0, LOAD=1 edge
    @(negedge clk);
    reset = 1'b1; LOAD = 1'b1; sel = 3'd0; IN = 20'hCAFE1;
    @(posedge clk); #1 check("reset_clears", 20'h00000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1 check("write_resumes", 20'hCAFE1);
    @(negedge clk);
    LOAD = 1'b0; sel = 3'd7;
    #1 check("others_still_clear", 20'h00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
